// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB requester port between N_REQ clients.
// Each granted command runs a fixed SETUP/ACCESS transfer. The read data and
// the error flag go back to the winning client, and completed transfers are counted.
module apb_rr_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ack,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [CNT_W-1:0]          xfer_count,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      psaterr
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0]    req_ack_q, req_ack_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    xfer_count_q, xfer_count_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic [ADDR_W-1:0]   addr_arr  [N_REQ];
  logic [DATA_W-1:0]   wdata_arr [N_REQ];
  logic                found;
  logic [IDX_W-1:0]    winner;
  int unsigned         cand;
  logic [IDX_W-1:0]    cand_idx;

  // Unpack the flattened client buses into per-client slices
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin search: first requester after last_grant, with wrap
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = 32'(last_grant_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_valid[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    req_ack_d    = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    xfer_count_d = xfer_count_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          pwrite_d          = req_write[winner];
          paddr_d           = addr_arr[winner];
          pwdata_d          = wdata_arr[winner];
          psel_d            = 1'b1;
          penable_d         = 1'b0;
          req_ack_d[winner] = 1'b1;
          owner_d           = winner;
          state_d           = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        rsp_rdata_d          = prdata;
        rsp_err_d            = psaterr;
        rsp_valid_d[owner_q] = 1'b1;
        xfer_count_d         = xfer_count_q + CNT_W'(1);
        last_grant_d         = owner_q;
        psel_d               = 1'b0;
        penable_d            = 1'b0;
        state_d              = S_IDLE;
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transfer immediately
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      owner_q      <= '0;
      req_ack_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      xfer_count_q <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      req_ack_q    <= req_ack_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      xfer_count_q <= xfer_count_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

  assign req_ack    = req_ack_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign xfer_count = xfer_count_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: a default instance plus a 2-bit-counter instance.
module tb_apb_rr_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  prdata;
  logic        psaterr;

  logic [1:0]  req_ack, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, busy, psel, penable, pwrite;
  logic [15:0] xfer_count;
  logic [2:0]  paddr;
  logic [7:0]  pwdata;

  logic [1:0]  req_ack2, rsp_valid2;
  logic [7:0]  rsp_rdata2;
  logic        rsp_err2, busy2, psel2, penable2, pwrite2;
  logic [1:0]  xfer_count2;
  logic [2:0]  paddr2;
  logic [7:0]  pwdata2;

  int n_total = 0;
  int n_pass  = 0;
  int ord  [4] = '{0, 1, 0, 1};
  int exp6 [5] = '{1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  apb_rr_arbiter dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .xfer_count(xfer_count), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .psaterr(psaterr)
  );

  apb_rr_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .busy(busy2), .xfer_count(xfer_count2), .psel(psel2), .penable(penable2),
    .pwrite(pwrite2), .paddr(paddr2), .pwdata(pwdata2), .prdata(prdata),
    .psaterr(psaterr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    psaterr   = 1'b0;
    cyc();
    cyc();
    chk("rst_psel",  32'(psel), 0);
    chk("rst_ack",   32'(req_ack), 0);
    chk("rst_rsp",   32'(rsp_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_cnt",   32'(xfer_count), 0);
    chk("rst_paddr", 32'(paddr), 0);
    #3 n_rst = 1'b1;
    cyc();

    // 1: client0 writes 0xA5 to address 3
    req_valid = 2'b01; req_write = 2'b01; req_addr = 6'o03; req_wdata = 16'h00A5;
    cyc();
    chk("t1_ack",     32'(req_ack), 32'h1);
    chk("t1_psel",    32'(psel), 1);
    chk("t1_pen0",    32'(penable), 0);
    chk("t1_busy",    32'(busy), 1);
    req_valid = 2'b00;
    cyc();
    chk("t1_pen1",    32'(penable), 1);
    chk("t1_ackclr",  32'(req_ack), 0);
    chk("t1_paddr",   32'(paddr), 3);
    chk("t1_pwdata",  32'(pwdata), 32'hA5);
    chk("t1_pwrite",  32'(pwrite), 1);
    cyc();
    chk("t1_rsp",     32'(rsp_valid), 32'h1);
    chk("t1_psel_lo", 32'(psel), 0);
    chk("t1_cnt",     32'(xfer_count), 1);
    chk("t1_idle",    32'(busy), 0);
    cyc();
    chk("t1_rspclr",  32'(rsp_valid), 0);
    chk("t1_hold",    32'(paddr), 3);

    // 2: client1 reads address 2, subordinate returns 0x5C
    req_valid = 2'b10; req_write = 2'b00; req_addr = 6'o20; prdata = 8'h5C; psaterr = 1'b0;
    cyc();
    chk("t2_ack",    32'(req_ack), 32'h2);
    chk("t2_pwrite", 32'(pwrite), 0);
    chk("t2_paddr",  32'(paddr), 2);
    req_valid = 2'b00;
    cyc();
    cyc();
    chk("t2_rsp",    32'(rsp_valid), 32'h2);
    chk("t2_rdata",  32'(rsp_rdata), 32'h5C);
    chk("t2_err",    32'(rsp_err), 0);
    chk("t2_cnt",    32'(xfer_count), 2);

    // 3: both clients request continuously; grant alternates 0,1,0,1
    req_valid = 2'b11; req_write = 2'b11; req_addr = 6'o61; req_wdata = 16'h3311;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_ack",   32'(req_ack), 32'(1 << ord[i]));
      chk("t3_psel",  32'(psel), 1);
      chk("t3_paddr", 32'(paddr), (ord[i] == 0) ? 1 : 6);
      cyc();
      cyc();
      chk("t3_rsp",   32'(rsp_valid), 32'(1 << ord[i]));
      chk("t3_gap",   32'(psel), 0);
      chk("t3_cnt",   32'(xfer_count), 32'(3 + i));
    end
    req_valid = 2'b00;
    cyc();
    chk("t3_idle",   32'(psel), 0);

    // 4: client0 reads invalid address 7 with psaterr, client1 waits behind it
    req_valid = 2'b11; req_write = 2'b00; req_addr = 6'o57; prdata = 8'hEE; psaterr = 1'b1;
    cyc();
    chk("t4_ack0",   32'(req_ack), 32'h1);
    req_valid = 2'b10;
    cyc();
    cyc();
    chk("t4_rsp0",   32'(rsp_valid), 32'h1);
    chk("t4_err1",   32'(rsp_err), 1);
    chk("t4_rdata",  32'(rsp_rdata), 32'hEE);
    chk("t4_cnt",    32'(xfer_count), 7);
    prdata = 8'h33; psaterr = 1'b0;
    cyc();
    chk("t4_ack1",   32'(req_ack), 32'h2);
    chk("t4_paddr",  32'(paddr), 5);
    req_valid = 2'b00;
    cyc();
    cyc();
    chk("t4_rsp1",   32'(rsp_valid), 32'h2);
    chk("t4_err0",   32'(rsp_err), 0);
    chk("t4_rdata1", 32'(rsp_rdata), 32'h33);
    chk("t4_cnt2",   32'(xfer_count2), 0);

    // 5: reset asserted while the transfer is in ACCESS
    req_valid = 2'b10; req_write = 2'b10; req_addr = 6'o40; req_wdata = 16'h7700;
    cyc();
    chk("t5_ack",    32'(req_ack), 32'h2);
    req_valid = 2'b00;
    cyc();
    chk("t5_access", 32'(penable), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("t5_psel",   32'(psel), 0);
    chk("t5_pen",    32'(penable), 0);
    chk("t5_busy",   32'(busy), 0);
    chk("t5_cnt",    32'(xfer_count), 0);
    cyc();
    chk("t5_norsp",  32'(rsp_valid), 0);
    #3 n_rst = 1'b1;
    req_valid = 2'b11; req_write = 2'b00; req_addr = 6'o12;
    cyc();
    chk("t5_first0", 32'(req_ack), 32'h1);
    req_valid = 2'b00;
    cyc();
    cyc();
    chk("t5_rsp",    32'(rsp_valid), 32'h1);
    chk("t5_cnt1",   32'(xfer_count), 1);

    // 6: counter wrap on the 2-bit instance over five transfers after reset
    n_rst = 1'b0;
    #2 n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 2'b01; req_write = 2'b01; req_addr = 6'o04; req_wdata = 16'(i);
      cyc();
      chk("t6_ack",  32'(req_ack2), 32'h1);
      req_valid = 2'b00;
      cyc();
      cyc();
      chk("t6_rsp",  32'(rsp_valid2), 32'h1);
      chk("t6_cnt2", 32'(xfer_count2), 32'(exp6[i]));
      chk("t6_cnt",  32'(xfer_count), 32'(i + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
